// File: rtl/lss5b_checker.sv
// lss5b_checker: self-synchronising checker for the 5-bit lss5b sequence.
// It predicts each word from the previous one, locks after a run of correct
// words, and reports and counts mismatches while locked.
module lss5b_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_ERR = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic [4:0]       din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RUN_W  = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT + 1)   : 1;
    localparam int MISS_W = (UNLOCK_ERR > 1) ? $clog2(UNLOCK_ERR + 1) : 1;

    localparam logic SEARCH = 1'b0;
    localparam logic LOCKED = 1'b1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_ERR - 1);

    logic              state_reg;
    logic [4:0]        prev_reg;
    logic              have_prev_reg;
    logic [RUN_W-1:0]  run_reg;
    logic [MISS_W-1:0] miss_reg;
    logic              err_reg;
    logic [ERR_W-1:0]  err_cnt_reg;

    logic [4:0] pred;
    logic       compare;
    logic       match;
    logic       mismatch;
    logic       counted_err;

    // Generator next-state function applied to the last received word.
    function automatic logic [4:0] lss5b_next(input logic [4:0] p);
        lss5b_next = {p[3] ^ p[4], p[2] | p[4], p[1], p[0], p[4]};
    endfunction

    // Compare the arriving word with the prediction; all-zero is never legal.
    always_comb begin
        pred        = lss5b_next(prev_reg);
        compare     = vld & have_prev_reg;
        match       = compare & (din == pred) & (din != 5'b00000);
        mismatch    = compare & ~match;
        counted_err = mismatch & (state_reg == LOCKED);
    end

    // Seed register, run/miss counters and the SEARCH/LOCKED state machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= SEARCH;
            prev_reg      <= 5'b00000;
            have_prev_reg <= 1'b0;
            run_reg       <= '0;
            miss_reg      <= '0;
        end else if (vld) begin
            prev_reg      <= din;
            have_prev_reg <= 1'b1;
            if (compare) begin
                if (state_reg == SEARCH) begin
                    if (match) begin
                        if (run_reg == RUN_LAST) begin
                            state_reg <= LOCKED;
                            run_reg   <= '0;
                            miss_reg  <= '0;
                        end else begin
                            run_reg <= run_reg + 1'b1;
                        end
                    end else begin
                        run_reg <= '0;
                    end
                end else begin
                    if (match) begin
                        miss_reg <= '0;
                    end else if (miss_reg == MISS_LAST) begin
                        state_reg <= SEARCH;
                        run_reg   <= '0;
                        miss_reg  <= '0;
                    end else begin
                        miss_reg <= miss_reg + 1'b1;
                    end
                end
            end
        end
    end

    // Error pulse and saturating error counter; clear wins except for a
    // simultaneous counted error, which leaves the count at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            err_reg <= counted_err;
            if (clr) begin
                err_cnt_reg <= counted_err ? ERR_W'(1) : '0;
            end else if (counted_err && (err_cnt_reg != {ERR_W{1'b1}})) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign locked  = (state_reg == LOCKED);
    assign err     = err_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_lss5b_checker.sv
// Testbench for lss5b_checker: directed scenarios plus a randomized stream,
// checked every cycle against a behavioural model of the lock rules.
module tb_lss5b_checker;

    logic       clk;
    logic       rst;
    logic       vld;
    logic [4:0] din;
    logic       clr;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    bit done   = 0;

    lss5b_checker #(.LOCK_CNT(4), .UNLOCK_ERR(3), .ERR_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld),
        .din     (din),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator step written straight from the bit equations.
    function automatic logic [4:0] f(input logic [4:0] p);
        logic [4:0] n;
        n[0] = p[4];
        n[1] = p[0];
        n[2] = p[1];
        n[3] = p[2] | p[4];
        n[4] = p[3] ^ p[4];
        return n;
    endfunction

    // Behavioural model: streak counts as plain integers.
    bit         m_have;
    logic [4:0] m_prev;
    bit         m_lock;
    int         m_good;
    int         m_bad;
    int         m_cnt;
    bit         m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_have = 0; m_prev = 5'd0; m_lock = 0;
            m_good = 0; m_bad = 0; m_cnt = 0; m_err = 0;
        end else begin
            bit good, counted;
            counted = 0;
            if (vld) begin
                if (m_have) begin
                    good = (din == f(m_prev)) && (din != 5'd0);
                    if (!m_lock) begin
                        m_good = good ? m_good + 1 : 0;
                        if (m_good == 4) begin
                            m_lock = 1; m_good = 0; m_bad = 0;
                        end
                    end else if (good) begin
                        m_bad = 0;
                    end else begin
                        counted = 1;
                        m_bad = m_bad + 1;
                        if (m_bad == 3) begin
                            m_lock = 0; m_good = 0; m_bad = 0;
                        end
                    end
                end
                m_prev = din;
                m_have = 1;
            end
            if (clr) m_cnt = counted ? 1 : 0;
            else if (counted) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            m_err = counted;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!done) begin
            checks++;
            if (locked !== m_lock || err !== m_err || err_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got locked=%0b err=%0b err_cnt=%0d, expected locked=%0b err=%0b err_cnt=%0d",
                         $time, locked, err, err_cnt, m_lock, m_err, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Present one word for one clock; outputs reflect it on return.
    task automatic step(input logic [4:0] w, input bit v, input bit c);
        din = w; vld = v; clr = c;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] g;
    logic [4:0] seq [5];

    initial begin
        rst = 1'b0; vld = 1'b0; din = 5'd0; clr = 1'b0;
        seq[0] = 5'b11111; seq[1] = 5'b01111; seq[2] = 5'b11110;
        seq[3] = 5'b01101; seq[4] = 5'b11010;
        #12 rst = 1'b1;
        chk("reset_locked", int'(locked), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);

        // 1: lock from generator reset
        g = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("gen_word%0d", i), int'(g), int'(seq[i]));
            step(g, 1, 0);
            g = f(g);
            if (i == 3) chk("t1_not_locked_after_4", int'(locked), 0);
        end
        chk("t1_locked_after_5", int'(locked), 1);
        chk("t1_err_cnt", int'(err_cnt), 0);

        // 2: single corrupted word gives two errors
        while (g != 5'b11010) begin step(g, 1, 0); g = f(g); end
        step(5'b11011, 1, 0); g = f(g);
        chk("t2_err_first", int'(err), 1);
        step(g, 1, 0); g = f(g);
        chk("t2_err_second", int'(err), 1);
        step(g, 1, 0); g = f(g);
        chk("t2_err_quiet", int'(err), 0);
        chk("t2_err_cnt", int'(err_cnt), 2);
        chk("t2_locked", int'(locked), 1);
        step(g, 1, 1); g = f(g);
        chk("t2_clr", int'(err_cnt), 0);

        // 3: stuck word unlocks after three errors, then relock
        for (int i = 0; i < 3; i++) begin
            step(5'b11111, 1, 0);
            chk($sformatf("t3_err_%0d", i), int'(err), 1);
        end
        chk("t3_err_cnt", int'(err_cnt), 3);
        chk("t3_unlocked", int'(locked), 0);
        for (int i = 0; i < 5; i++) begin
            step(g, 1, 0); g = f(g);
            if (i == 3) chk("t3_not_locked_yet", int'(locked), 0);
        end
        chk("t3_relocked", int'(locked), 1);

        // 4: all-zero input never locks and never errors
        rst = 1'b0; #3 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(5'b00000, 1, 0);
            if (locked !== 1'b0 || err !== 1'b0) chk("t4_zero_stream", 1, 0);
        end
        chk("t4_locked", int'(locked), 0);
        chk("t4_err_cnt", int'(err_cnt), 0);

        // 5: gapped valid, then clear with a simultaneous error
        g = 5'b11111;
        for (int i = 0; i < 5; i++) begin step(g, 1, 0); g = f(g); end
        for (int i = 0; i < 8; i++) begin
            step(g, 1, 0); g = f(g);
            step(5'($urandom), 0, 0);
        end
        chk("t5_locked", int'(locked), 1);
        chk("t5_err_cnt", int'(err_cnt), 0);
        step(g ^ 5'b00100, 1, 1); g = f(g);
        chk("t5_clr_with_err", int'(err_cnt), 1);
        chk("t5_err_pulse", int'(err), 1);
        for (int i = 0; i < 4; i++) begin step(g, 1, 0); g = f(g); end
        chk("t5_err_cnt_after", int'(err_cnt), 2);

        // 6: asynchronous reset mid-lock
        chk("t6_locked_before", int'(locked), 1);
        rst = 1'b0;
        #1;
        chk("t6_async_locked", int'(locked), 0);
        chk("t6_async_err_cnt", int'(err_cnt), 0);
        #24 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(g, 1, 0); g = f(g);
            if (i == 3) chk("t6_not_locked_yet", int'(locked), 0);
        end
        chk("t6_relocked", int'(locked), 1);

        // Randomized stream: gaps, corruptions, clears, zero words
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit v, c;
            logic [4:0] w;
            r = int'($urandom_range(0, 99));
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            w = g;
            if (r < 4) w = g ^ 5'($urandom_range(1, 31));
            else if (r == 4) w = 5'd0;
            else if (r == 5) w = 5'b11111;
            if (!v) w = 5'($urandom);
            step(w, v, c);
            if (v) g = (w == 5'd0) ? 5'b11111 : f(g);
        end

        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
